rcon_seq: RTL and testbench

Sequential AES round-constant generator for the key-expansion pipeline, replacing fixed-table lookup with on-the-fly GF(2^8) doubling. Supports AES-128, AES-192 and AES-256 schedules selected per run, and delivers one Rcon word per valid/ready transfer. The key-expansion controller starts a run, consumes constants as it builds each key word group, and receives a done pulse after the final constant.

---
 rtl/rcon_seq.sv | 154 +++++++++++++++
 tb/tb_rcon_seq.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rcon_seq.sv
`default_nettype none
// ============================================================================
//  Module   : rcon_seq
//  Purpose  : Sequential AES round-constant generator. Produces the Rcon
//             sequence for AES-128/192/256 key expansion by GF(2^8) doubling
//             and hands out one constant per valid/ready transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module rcon_seq #(
    parameter int          BYTE_POS = 3,
    parameter logic [7:0]  POLY     = 8'h1B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  key_mode,
    input  logic        abort,
    input  logic        rcon_ready,
    output logic        rcon_valid,
    output logic [31:0] rcon,
    output logic [3:0]  rcon_idx,
    output logic        rcon_last,
    output logic        busy,
    output logic        done,
    output logic        mode_err
);

    // Index of the final constant for each schedule (run length minus one).
    localparam logic [3:0] c_LAST_IDX_128 = 4'd9;
    localparam logic [3:0] c_LAST_IDX_192 = 4'd7;
    localparam logic [3:0] c_LAST_IDX_256 = 4'd6;
    localparam logic [1:0] c_MODE_RSVD    = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_byte;
    logic [7:0] w_byte_nxt;
    logic [3:0] r_idx;
    logic [3:0] w_idx_nxt;
    logic [3:0] r_last_idx;
    logic [3:0] w_last_idx_nxt;
    logic       r_mode_err;
    logic       w_mode_err_nxt;
    logic       w_valid;
    logic [7:0] w_lane_byte;

    // Multiply by x in GF(2^8): shift left, reduce when bit 7 falls out.
    function automatic logic [7:0] gf_double(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
    endfunction

    // Reserved mode runs the AES-256 length.
    function automatic logic [3:0] last_idx_for(input logic [1:0] mode);
        logic [3:0] v;
        case (mode)
            2'd0:    v = c_LAST_IDX_128;
            2'd1:    v = c_LAST_IDX_192;
            default: v = c_LAST_IDX_256;
        endcase
        return v;
    endfunction

    // State and datapath registers; reset forces every output low at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_byte     <= 8'h00;
            r_idx      <= 4'd0;
            r_last_idx <= 4'd0;
            r_mode_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte     <= w_byte_nxt;
            r_idx      <= w_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
            r_mode_err <= w_mode_err_nxt;
        end
    end

    // Next-state and next-datapath decode; abort outranks any transfer.
    always_comb begin
        w_state_nxt    = r_state;
        w_byte_nxt     = r_byte;
        w_idx_nxt      = r_idx;
        w_last_idx_nxt = r_last_idx;
        w_mode_err_nxt = r_mode_err;
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_state_nxt    = S_RUN;
                    w_byte_nxt     = 8'h01;
                    w_idx_nxt      = 4'd0;
                    w_last_idx_nxt = last_idx_for(key_mode);
                    w_mode_err_nxt = (key_mode == c_MODE_RSVD);
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_byte_nxt  = 8'h00;
                    w_idx_nxt   = 4'd0;
                end else if (rcon_ready) begin
                    if (r_idx == r_last_idx) begin
                        // Final transfer: park the datapath cleared.
                        w_state_nxt = S_DONE;
                        w_byte_nxt  = 8'h00;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_byte_nxt = gf_double(r_byte);
                        w_idx_nxt  = r_idx + 4'd1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_byte_nxt  = 8'h00;
                w_idx_nxt   = 4'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_byte_nxt  = 8'h00;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded purely from registered state.
    assign w_valid     = (r_state == S_RUN);
    assign w_lane_byte = w_valid ? r_byte : 8'h00;

    // Place the constant in its byte lane; the other lanes stay zero.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        if (g == BYTE_POS) begin : g_active
            assign rcon[8*g +: 8] = w_lane_byte;
        end else begin : g_zero
            assign rcon[8*g +: 8] = 8'h00;
        end
    end

    assign rcon_valid = w_valid;
    assign rcon_idx   = r_idx;
    assign rcon_last  = w_valid && (r_idx == r_last_idx);
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign mode_err   = r_mode_err;

endmodule
`default_nettype wire

// File: tb/tb_rcon_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rcon_seq
//  Purpose  : Directed self-checking bench for rcon_seq (BYTE_POS 3 and 0).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rcon_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  key_mode;
    logic        abort;
    logic        rcon_ready;

    logic        rcon_valid, rcon_last, busy, done, mode_err;
    logic [31:0] rcon;
    logic [3:0]  rcon_idx;

    logic        rcon_valid0, rcon_last0, busy0, done0, mode_err0;
    logic [31:0] rcon0;
    logic [3:0]  rcon_idx0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_b [10];

    rcon_seq #(.BYTE_POS(3), .POLY(8'h1B)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_mode(key_mode),
        .abort(abort), .rcon_ready(rcon_ready), .rcon_valid(rcon_valid),
        .rcon(rcon), .rcon_idx(rcon_idx), .rcon_last(rcon_last),
        .busy(busy), .done(done), .mode_err(mode_err)
    );

    rcon_seq #(.BYTE_POS(0), .POLY(8'h1B)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .key_mode(key_mode),
        .abort(abort), .rcon_ready(rcon_ready), .rcon_valid(rcon_valid0),
        .rcon(rcon0), .rcon_idx(rcon_idx0), .rcon_last(rcon_last0),
        .busy(busy0), .done(done0), .mode_err(mode_err0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run with ready held high; optional start pokes mid-run.
    task automatic run_seq(input logic [1:0] mode, input int len, input logic exp_err, input bit poke);
        start = 1'b1; key_mode = mode; rcon_ready = 1'b1;
        tick();
        start = 1'b0;
        check("mode_err_run", mode_err, exp_err);
        for (int i = 0; i < len; i++) begin
            check("valid", rcon_valid, 1);
            check("rcon", rcon, {exp_b[i], 24'h0});
            check("rcon_b0", rcon0, {24'h0, exp_b[i]});
            check("idx", rcon_idx, i[3:0]);
            check("last", rcon_last, (i == len - 1));
            check("done_in_run", done, 0);
            if (poke && (i == 2 || i == 3)) begin
                start = 1'b1; key_mode = 2'd0;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("valid_m1", rcon_valid, 0);
        check("busy_m1", busy, 1);
        check("done_m1", done, 1);
        tick();
        check("busy_m2", busy, 0);
        check("done_m2", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pat;
        int k, cyc;
        logic rdy;

        exp_b = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
        rst_n = 1'b0; start = 1'b0; key_mode = 2'd0; abort = 1'b0; rcon_ready = 1'b0;
        tick(); tick();
        check("rst_valid", rcon_valid, 0);
        check("rst_rcon", rcon, 0);
        check("rst_idx", rcon_idx, 0);
        check("rst_last", rcon_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", mode_err, 0);
        rst_n = 1'b1;
        tick();

        run_seq(2'd0, 10, 1'b0, 1'b0);
        run_seq(2'd1, 8, 1'b0, 1'b0);
        run_seq(2'd2, 7, 1'b0, 1'b0);

        // AES-256 with a fixed irregular ready pattern.
        pat = 32'hA5C3_6E91;
        start = 1'b1; key_mode = 2'd2; rcon_ready = 1'b0;
        tick();
        start = 1'b0;
        k = 0; cyc = 0;
        while (k < 7 && cyc < 32) begin
            check("tg_valid", rcon_valid, 1);
            check("tg_rcon", rcon, {exp_b[k], 24'h0});
            check("tg_idx", rcon_idx, k[3:0]);
            check("tg_last", rcon_last, (k == 6));
            rdy = pat[cyc];
            rcon_ready = rdy;
            tick();
            if (rdy) k++;
            cyc++;
        end
        check("tg_xfers", k, 7);
        check("tg_done", done, 1);
        check("tg_valid_end", rcon_valid, 0);
        rcon_ready = 1'b1;
        tick();

        // Abort at idx 4 together with ready.
        start = 1'b1; key_mode = 2'd0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("ab_idx", rcon_idx, 4);
        check("ab_rcon", rcon, 32'h1000_0000);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_valid", rcon_valid, 0);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        check("ab_idx_clr", rcon_idx, 0);
        tick();
        check("ab_done2", done, 0);
        run_seq(2'd0, 10, 1'b0, 1'b0);

        // start with abort in IDLE stays idle.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", busy, 0);

        // Reserved mode, with start pokes mid-run that must be ignored.
        run_seq(2'd3, 7, 1'b1, 1'b1);
        tick();
        check("err_sticky", mode_err, 1);
        run_seq(2'd0, 10, 1'b0, 1'b0);

        // Async reset at idx 5 on the lane-0 build.
        start = 1'b1; key_mode = 2'd0; rcon_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("r0_idx5", rcon_idx0, 5);
        check("r0_rcon5", rcon0, 32'h0000_0020);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", rcon_valid0, 0);
        check("ar_rcon", rcon0, 0);
        check("ar_idx", rcon_idx0, 0);
        check("ar_last", rcon_last0, 0);
        check("ar_busy", busy0, 0);
        check("ar_done", done0, 0);
        check("ar_err", mode_err0, 0);
        check("ar_busy3", busy, 0);
        #1;
        rst_n = 1'b1;
        tick();
        check("ar_post_busy", busy0, 0);
        check("ar_post_done", done0, 0);
        run_seq(2'd0, 10, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
